// File: rtl/piso_8bit_serializer_pkg.sv
// Shared definitions for the PISO serializer: FSM state encoding and default word width.
package piso_8bit_serializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/piso_hold_buf.sv
// One-word holding buffer. It is written on load, and take releases it back to empty.
module piso_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             load,
    input  logic             take,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] data,
    output logic             full
);

    // load and take never coincide: load needs an empty buffer, and take needs a full one.
    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            data <= '0;
            full <= 1'b0;
        end else if (load) begin
            data <= din;
            full <= 1'b1;
        end else if (take) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/piso_8bit_serializer.sv
// Parallel-in serial-out serializer, MSB first. A one-word holding buffer allows
// gapless back-to-back words.
module piso_8bit_serializer
    import piso_8bit_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rs,
    input  logic [WIDTH-1:0] pi,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int             CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST       = CW'(WIDTH - 1);
    localparam logic           ONE_BIT_WD = (WIDTH == 1);

    state_t            state_r;
    logic [WIDTH-1:0]  shift_r;
    logic [CW-1:0]     count_r;
    logic              done_r;

    logic              hold_full_s;
    logic [WIDTH-1:0]  hold_data_s;
    logic              accept_s;
    logic              last_s;
    logic              buf_load_s;
    logic              buf_take_s;
    logic [CW-1:0]     next_count_s;

    assign load_ready   = ~hold_full_s;
    assign accept_s     = load_valid & load_ready;
    assign last_s       = (state_r == SHIFT) && (count_r == LAST);
    assign next_count_s = count_r + CW'(1);

    // Words accepted on the last-bit cycle bypass the buffer and go straight into the shifter.
    assign buf_load_s   = accept_s & (state_r == SHIFT) & ~last_s;
    assign buf_take_s   = last_s & hold_full_s;

    piso_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold_buf (
        .clk  (clk),
        .rs   (rs),
        .load (buf_load_s),
        .take (buf_take_s),
        .din  (pi),
        .data (hold_data_s),
        .full (hold_full_s)
    );

    // Serializer FSM: shift register, bit counter and the registered done flag.
    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            state_r <= IDLE;
            shift_r <= '0;
            count_r <= '0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r <= SHIFT;
                        shift_r <= pi;
                        count_r <= '0;
                        done_r  <= ONE_BIT_WD;
                    end
                end
                SHIFT: begin
                    if (last_s) begin
                        if (hold_full_s) begin
                            shift_r <= hold_data_s;
                            count_r <= '0;
                            done_r  <= ONE_BIT_WD;
                        end else if (accept_s) begin
                            shift_r <= pi;
                            count_r <= '0;
                            done_r  <= ONE_BIT_WD;
                        end else begin
                            state_r <= IDLE;
                            shift_r <= '0;
                            count_r <= '0;
                            done_r  <= 1'b0;
                        end
                    end else begin
                        shift_r <= shift_r << 1;
                        count_r <= next_count_s;
                        done_r  <= (next_count_s == LAST);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    shift_r <= '0;
                    count_r <= '0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // The shifter is cleared on the way back to IDLE, so its MSB is already 0 there.
    assign sout       = shift_r[WIDTH-1];
    assign sout_valid = (state_r == SHIFT);
    assign busy       = (state_r == SHIFT);
    assign done       = done_r;

endmodule

// File: tb/tb_piso_8bit_serializer.sv
// Directed bench for piso_8bit_serializer: a per-cycle vector table plus hand-written
// backpressure, reset and loopback sequences.
module tb_piso_8bit_serializer;

    logic       clk = 1'b0;
    logic       rs;
    logic [7:0] pi;
    logic       load_valid;
    logic       load_ready;
    logic       sout;
    logic       sout_valid;
    logic       busy;
    logic       done;

    logic [7:0] sipo;
    int         n_tests = 0;
    int         n_fail  = 0;

    // {load_ready, sout, sout_valid, busy, done} observed after one clock edge
    typedef struct {
        logic [7:0] pi;
        logic       lv;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    piso_8bit_serializer #(.WIDTH(8)) dut (
        .clk        (clk),
        .rs         (rs),
        .pi         (pi),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .busy       (busy),
        .done       (done)
    );

    // Loopback receiver: serial-in parallel-out register
    always_ff @(posedge clk or posedge rs) begin
        if (rs)
            sipo <= 8'h00;
        else if (sout_valid)
            sipo <= {sipo[6:0], sout};
    end

    function automatic logic [4:0] outs();
        return {load_ready, sout, sout_valid, busy, done};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [7:0] p, input logic l, input logic [4:0] e);
        vec_t v;
        v.pi  = p;
        v.lv  = l;
        v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0]  w;
        logic [7:0]  w2;
        logic [15:0] got;
        int          nbits;
        int          stray;

        rs = 1'b1;
        pi = 8'h00;
        load_valid = 1'b0;
        #12;
        check("reset_outs", outs(), 5'b10000);
        tick();
        rs = 1'b0;
        tick();
        check("idle_after_reset", outs(), 5'b10000);

        // Single word 11101001
        w = 8'b11101001;
        for (int k = 0; k < 8; k++)
            add((k == 0) ? w : 8'h00, (k == 0), {1'b1, w[7-k], 1'b1, 1'b1, (k == 7)});
        add(8'h00, 1'b0, 5'b10000);

        // Back-to-back A5 then 3C: 3C waits in the holding buffer
        w  = 8'hA5;
        w2 = 8'h3C;
        for (int k = 0; k < 8; k++)
            add((k == 0) ? w : ((k == 1) ? w2 : 8'h00), (k < 2),
                {(k == 0), w[7-k], 1'b1, 1'b1, (k == 7)});
        for (int k = 0; k < 8; k++)
            add(8'h00, 1'b0, {1'b1, w2[7-k], 1'b1, 1'b1, (k == 7)});
        add(8'h00, 1'b0, 5'b10000);

        // 5A then C3 offered exactly on the last-bit cycle: direct load with no gap
        w  = 8'h5A;
        w2 = 8'hC3;
        for (int k = 0; k < 8; k++)
            add((k == 0) ? w : 8'h00, (k == 0), {1'b1, w[7-k], 1'b1, 1'b1, (k == 7)});
        for (int k = 0; k < 8; k++)
            add((k == 0) ? w2 : 8'h00, (k == 0), {1'b1, w2[7-k], 1'b1, 1'b1, (k == 7)});
        add(8'h00, 1'b0, 5'b10000);

        foreach (vecs[i]) begin
            pi = vecs[i].pi;
            load_valid = vecs[i].lv;
            tick();
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end
        load_valid = 1'b0;

        // Backpressure: FF shifting, 00 buffered, 81 offered and refused
        got = 16'h0000;
        nbits = 0;
        pi = 8'hFF; load_valid = 1'b1;
        tick();
        if (sout_valid) begin got = {got[14:0], sout}; nbits++; end
        pi = 8'h00;
        tick();
        if (sout_valid) begin got = {got[14:0], sout}; nbits++; end
        pi = 8'h81;
        for (int i = 0; i < 7; i++) begin
            check($sformatf("bp_ready%0d", i), load_ready, 1'b0);
            tick();
            if (sout_valid) begin got = {got[14:0], sout}; nbits++; end
        end
        load_valid = 1'b0;
        pi = 8'h00;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (sout_valid) begin got = {got[14:0], sout}; nbits++; end
        end
        tick();
        check("bp_bits", got, 16'hFF00);
        check("bp_nbits", nbits, 16);
        check("bp_idle", outs(), 5'b10000);

        // Reset mid-word: F0 in flight after 3 bits, 55 buffered
        pi = 8'hF0; load_valid = 1'b1;
        tick();
        pi = 8'h55;
        tick();
        load_valid = 1'b0;
        tick();
        check("rst_pre_bit3", {sout, sout_valid, load_ready}, 3'b110);
        #2;
        rs = 1'b1;
        #1;
        check("rst_async_outs", outs(), 5'b10000);
        check("rst_sipo", sipo, 8'h00);
        tick();
        rs = 1'b0;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (sout_valid || busy || done || sout) stray++;
        end
        check("rst_no_residual", stray, 0);
        check("rst_ready", load_ready, 1'b1);

        // First word after reset, 4B buffered behind it, checked through the loopback SIPO
        pi = 8'h96; load_valid = 1'b1;
        tick();
        check("post_rst_first", outs(), 5'b11110);
        pi = 8'h4B;
        tick();
        load_valid = 1'b0;
        pi = 8'h00;
        for (int i = 0; i < 7; i++) tick();
        check("loop_word0", sipo, 8'h96);
        for (int i = 0; i < 8; i++) tick();
        check("loop_word1", sipo, 8'h4B);
        tick();
        check("loop_idle", outs(), 5'b10000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
